dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared core definitions for the MEM-stage data-memory responder.
//   dmem_state_e : responder FSM state (IDLE/ISSUE/WAIT/DONE, 2-bit encoding)
//   DMEM_ADDR_W  : default word-address width of the backing RAM bus
package dmem_responder_pkg;

    localparam int unsigned DMEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_responder.sv
// dmem_responder
//   Runs the MEM-stage load/store over a valid/ready request bus and a
//   response bus to backing RAM. Holds the whole pipeline with a
//   combinational stall while the access is in flight, and registers load
//   data for MEM/WB.
//
// Ports
//   clk, rstn              : clock, synchronous active-low reset
//   memread_mem            : load request from EX/MEM
//   memwrite_mem           : store request from EX/MEM (wins over load)
//   alu_result_mem         : byte address; bits [ADDR_W+1:2] form the word address
//   write_data_memory_mem  : store data
//   data_ready_mem         : 0 = stall PC and all pipeline registers
//   data_from_memory_mem   : last completed load result
//   mem_req_valid/ready    : backing-bus request handshake
//   mem_req_we/addr/wdata  : request fields, stable while valid is high
//   mem_resp_valid/rdata   : read data or write acknowledge
//   stall_cycles           : saturating count of stalled cycles
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              memread_mem,
    input  logic              memwrite_mem,
    input  logic [31:0]       alu_result_mem,
    input  logic [31:0]       write_data_memory_mem,
    output logic              data_ready_mem,
    output logic [31:0]       data_from_memory_mem,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_rdata,
    output logic [CNT_W-1:0]  stall_cycles
);

    dmem_state_e       state_q;
    logic              valid_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;
    logic              req_present;
    logic              ready_d;

    // Byte-offset and high address bits are not decoded (word accesses only).
    logic unused_addr_bits;
    assign unused_addr_bits = ^alu_result_mem;

    assign req_present = memread_mem | memwrite_mem;

    // Responder FSM. DONE always returns to IDLE so the instruction still
    // sitting on the inputs during DONE is never issued a second time.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_present) begin
                        we_q    <= memwrite_mem;
                        addr_q  <= alu_result_mem[ADDR_W+1:2];
                        wdata_q <= write_data_memory_mem;
                        valid_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        // Store acknowledges leave the last load result intact.
                        if (!we_q) begin
                            rdata_q <= mem_resp_rdata;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The stall must drop in the same cycle the request appears, so it is
    // decoded from the current state and inputs rather than registered.
    always_comb begin
        ready_d = 1'b1;
        case (state_q)
            ST_IDLE:  ready_d = !req_present;
            ST_ISSUE: ready_d = 1'b0;
            ST_WAIT:  ready_d = 1'b0;
            ST_DONE:  ready_d = 1'b1;
            default:  ready_d = 1'b1;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!ready_d && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign data_ready_mem       = ready_d;
    assign data_from_memory_mem = rdata_q;
    assign mem_req_valid        = valid_q;
    assign mem_req_we           = we_q;
    assign mem_req_addr         = addr_q;
    assign mem_req_wdata        = wdata_q;
    assign stall_cycles         = stall_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned ADDR_W = DMEM_ADDR_W;
    localparam int unsigned CNT_W  = 32;

    logic              clk;
    logic              rstn;
    logic              memread_mem;
    logic              memwrite_mem;
    logic [31:0]       alu_result_mem;
    logic [31:0]       write_data_memory_mem;
    logic              data_ready_mem;
    logic [31:0]       data_from_memory_mem;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [31:0]       mem_req_wdata;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_rdata;
    logic [CNT_W-1:0]  stall_cycles;

    dmem_responder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .memread_mem           (memread_mem),
        .memwrite_mem          (memwrite_mem),
        .alu_result_mem        (alu_result_mem),
        .write_data_memory_mem (write_data_memory_mem),
        .data_ready_mem        (data_ready_mem),
        .data_from_memory_mem  (data_from_memory_mem),
        .mem_req_valid         (mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_we            (mem_req_we),
        .mem_req_addr          (mem_req_addr),
        .mem_req_wdata         (mem_req_wdata),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_rdata        (mem_resp_rdata),
        .stall_cycles          (stall_cycles)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] run;
        logic [31:0] total;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_done_cyc = 0;
    int unsigned gap_req = 0;
    int unsigned gap_seen = 0;
    int unsigned inject_cnt = 0;
    int unsigned ready_delay = 0;
    int unsigned resp_delay = 0;
    logic [31:0] exp_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Backing RAM model: configurable request-accept and response delays.
    initial begin
        logic [31:0] ram [256];
        int unsigned rdy_cnt;
        int unsigned rsp_cnt;
        int unsigned inject_done;
        bit          pending;
        logic        p_we;
        logic [7:0]  p_idx;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[4]  = 32'hDEAD_BEEF;
        ram[5]  = 32'h1111_1111;
        ram[7]  = 32'hCAFE_F00D;
        ram[20] = 32'hAAAA_AAAA;
        rdy_cnt = 0; rsp_cnt = 0; inject_done = 0; pending = 0; p_we = 0; p_idx = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            if (!rstn) begin
                pending = 0; rdy_cnt = 0; rsp_cnt = 0;
            end else begin
                if (inject_cnt != inject_done) begin
                    inject_done++;
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = 32'hBAD0_BAD0;
                end else if (pending) begin
                    if (rsp_cnt >= resp_delay) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_rdata = p_we ? 32'h0 : ram[p_idx];
                        pending = 0;
                    end else begin
                        rsp_cnt++;
                    end
                end
                if (mem_req_valid) begin
                    if (rdy_cnt >= ready_delay) begin
                        mem_req_ready = 1'b1;
                        rdy_cnt = 0; rsp_cnt = 0; pending = 1;
                        p_we  = mem_req_we;
                        p_idx = mem_req_addr[7:0];
                        if (mem_req_we) ram[p_idx] = mem_req_wdata;
                    end else begin
                        rdy_cnt++;
                    end
                end
            end
        end
    end

    // Monitor: checks request handshakes and access completions against the queues.
    initial begin
        int unsigned low_run;
        bit   prev_low, prev_hs, prev_stalled, prev_valid;
        req_t held, exp_r;
        done_t d;
        low_run = 0; prev_low = 0; prev_hs = 0; prev_stalled = 0; prev_valid = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                low_run = 0; prev_low = 0; prev_hs = 0; prev_stalled = 0; prev_valid = 0;
                continue;
            end
            if (prev_hs) check("valid_drop_after_accept", {31'b0, mem_req_valid}, 32'd0);
            if (prev_stalled) begin
                check("valid_held_until_ready", {31'b0, mem_req_valid}, 32'd1);
                check("stable_we", {31'b0, mem_req_we}, {31'b0, held.we});
                check("stable_addr", 32'(mem_req_addr), 32'(held.addr));
                check("stable_wdata", mem_req_wdata, held.wdata);
            end
            if (mem_req_valid && !prev_valid && (gap_req != gap_seen)) begin
                gap_seen++;
                check("b2b_issue_gap", cyc - last_done_cyc, 32'd2);
            end
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) begin
                    check("spurious_req", {31'b0, mem_req_valid}, 32'd0);
                end else begin
                    exp_r = req_q.pop_front();
                    check("req_we", {31'b0, mem_req_we}, {31'b0, exp_r.we});
                    check("req_addr", 32'(mem_req_addr), 32'(exp_r.addr));
                    check("req_wdata", mem_req_wdata, exp_r.wdata);
                end
            end
            if (!data_ready_mem) begin
                low_run++;
            end else if (prev_low) begin
                last_done_cyc = cyc;
                if (done_q.size() == 0) begin
                    check("spurious_done", {31'b0, data_ready_mem}, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    check("done_rdata", data_from_memory_mem, d.rdata);
                    check("stall_run", low_run, d.run);
                    check("stall_total", stall_cycles, d.total);
                end
                low_run = 0;
            end
            prev_low     = !data_ready_mem;
            prev_hs      = mem_req_valid && mem_req_ready;
            prev_stalled = mem_req_valid && !mem_req_ready;
            prev_valid   = mem_req_valid;
            held         = '{we: mem_req_we, addr: mem_req_addr, wdata: mem_req_wdata};
        end
    end

    task automatic wait_done();
        bit seen_low;
        bit ok;
        seen_low = 0; ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!data_ready_mem) seen_low = 1;
            else if (seen_low) begin
                ok = 1;
                break;
            end
        end
        check("access_completes", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] baddr,
                          input logic [31:0] wdata, input logic [ADDR_W-1:0] exp_waddr,
                          input logic [31:0] exp_rdata, input int unsigned exp_run);
        exp_total = exp_total + exp_run;
        req_q.push_back('{we: wr, addr: exp_waddr, wdata: wdata});
        done_q.push_back('{rdata: exp_rdata, run: exp_run, total: exp_total});
        memread_mem = rd; memwrite_mem = wr;
        alu_result_mem = baddr; write_data_memory_mem = wdata;
        wait_done();
    endtask

    task automatic idle(input int unsigned n);
        memread_mem = 1'b0; memwrite_mem = 1'b0;
        alu_result_mem = '0; write_data_memory_mem = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;
        bit in_wait;
        rstn = 1'b0;
        memread_mem = 1'b0; memwrite_mem = 1'b0;
        alu_result_mem = '0; write_data_memory_mem = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, data_ready_mem}, 32'd1);
        check("rst_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_we", {31'b0, mem_req_we}, 32'd0);
        check("rst_addr", 32'(mem_req_addr), 32'd0);
        check("rst_wdata", mem_req_wdata, 32'd0);
        check("rst_rdata", data_from_memory_mem, 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        memread_mem = 1'b1;
        #1;
        check("rst_ready_with_req", {31'b0, data_ready_mem}, 32'd0);
        memread_mem = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        // Zero-wait load
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 16'd4, 32'hDEAD_BEEF, 3);
        idle(2);
        // Store; inputs stay asserted through DONE
        access(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 16'd9, 32'hDEAD_BEEF, 3);
        idle(2);
        // Backpressure; unaligned byte offset and high address bits ignored
        ready_delay = 2; resp_delay = 2;
        access(1'b1, 1'b0, 32'hFFFC_001F, 32'h0F0F_0F0F, 16'd7, 32'hCAFE_F00D, 7);
        ready_delay = 0; resp_delay = 0;
        idle(2);
        // Back-to-back load then store
        access(1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000, 16'd9, 32'h1234_5678, 3);
        gap_req++;
        access(1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 16'd12, 32'h1234_5678, 3);
        idle(3);

        // Reset while waiting for the response, then a late response
        resp_delay = 1000;
        req_q.push_back('{we: 1'b0, addr: 16'd5, wdata: 32'h0000_0000});
        memread_mem = 1'b1; alu_result_mem = 32'h0000_0014; write_data_memory_mem = '0;
        saw_valid = 0; in_wait = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req_valid) saw_valid = 1;
            else if (saw_valid) begin
                in_wait = 1;
                break;
            end
        end
        check("reached_wait", {31'b0, in_wait}, 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b0; memread_mem = 1'b0; alu_result_mem = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        inject_cnt++;
        @(negedge clk);
        check("midrst_valid", {31'b0, mem_req_valid}, 32'd0);
        check("midrst_rdata", data_from_memory_mem, 32'd0);
        check("midrst_stall", stall_cycles, 32'd0);
        @(negedge clk);
        check("late_resp_ready", {31'b0, data_ready_mem}, 32'd1);
        check("late_resp_valid", {31'b0, mem_req_valid}, 32'd0);
        check("late_resp_rdata", data_from_memory_mem, 32'd0);
        check("late_resp_stall", stall_cycles, 32'd0);
        exp_total = 0;
        resp_delay = 0;
        @(posedge clk);
        #1;

        // Simultaneous read+write: store wins, load result retained
        access(1'b1, 1'b0, 32'h0000_0050, 32'h0000_0000, 16'd20, 32'hAAAA_AAAA, 3);
        access(1'b1, 1'b1, 32'h0000_0050, 32'h5555_5555, 16'd20, 32'hAAAA_AAAA, 3);
        access(1'b1, 1'b0, 32'h0000_0050, 32'h0000_0000, 16'd20, 32'h5555_5555, 3);
        idle(4);

        check("req_queue_drained", req_q.size(), 32'd0);
        check("done_queue_drained", done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
